// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared state encoding and constants for the seven-segment serial driver
package seven_segment_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT_LO = 2'd1;
    localparam logic [1:0] SHIFT_HI = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    localparam int SEG_BITS_PER_DIGIT = 8;

endpackage

// File: rtl/seven_segment_clk_divider.sv
// rtl/seven_segment_clk_divider.sv - phase counter producing a one-cycle phase_done every CLK_DIV cycles
module seven_segment_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    output logic phase_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Held at zero by restart; the terminal count wraps so consecutive phases need no restart.
    assign phase_done = !restart && (count == LAST);

    // Count 0..CLK_DIV-1 within each phase.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (restart || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seven_segment_serial_driver.sv
// rtl/seven_segment_serial_driver.sv - serialises a segment frame onto a 74HC595-style chain; SEVEN_SEGMENT_AUTO_REFRESH_EN adds idle resend
module seven_segment_serial_driver
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic                                       clock,
    input  logic                                       resetn,
    input  logic [NUM_DIGITS*SEG_BITS_PER_DIGIT-1:0]   D,
    input  logic                                       load,
    output logic                                       ready,
    output logic                                       busy,
    output logic                                       ser_data,
    output logic                                       ser_clk,
    output logic                                       ser_latch
);

    localparam int FW = NUM_DIGITS * SEG_BITS_PER_DIGIT;
    localparam int BW = $clog2(FW);

    if (CLK_DIV < 1 || CLK_DIV > 255 || NUM_DIGITS < 1 || REFRESH_CYCLES < 1) begin : g_param_check
        $error("seven_segment_serial_driver: illegal parameter value");
    end

    logic [1:0]    state;
    logic [FW-1:0] shift_reg;
    logic [FW-1:0] pending;
    logic          pending_valid;
    logic [BW-1:0] bit_cnt;
    logic          phase_done;
    logic          accept;
    logic          frame_end;
    logic          start_pending;
    logic          start_any;
    logic          pending_valid_next;
    logic [FW-1:0] next_frame;

    assign accept        = load && ready;
    assign frame_end     = (state == LATCH) && phase_done;
    assign start_pending = pending_valid && ((state == IDLE) || frame_end);

    // A new load wins over the transfer-clear so a frame posted on the consuming edge is kept.
    assign pending_valid_next = accept ? 1'b1 : (start_pending ? 1'b0 : pending_valid);

`ifdef SEVEN_SEGMENT_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [FW-1:0] last_frame;
    logic          have_last;
    logic [RW-1:0] idle_cnt;
    logic          refresh_go;

    assign refresh_go = (state == IDLE) && !pending_valid && !accept && have_last
                        && (idle_cnt == RW'(REFRESH_CYCLES - 1));
    assign start_any  = start_pending || refresh_go;
    assign next_frame = pending_valid ? pending : last_frame;

    // Remember the frame being started; it is only trusted once its latch pulse has completed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_frame <= '0;
            have_last  <= 1'b0;
        end else begin
            if (start_any && ((state == IDLE) || frame_end)) begin
                last_frame <= next_frame;
            end
            if (frame_end) begin
                have_last <= 1'b1;
            end
        end
    end

    // Idle time since the last activity; restarts on any load or when leaving IDLE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
        end else if ((state != IDLE) || accept || pending_valid || refresh_go) begin
            idle_cnt <= '0;
        end else if (have_last) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign start_any  = start_pending;
    assign next_frame = pending;
`endif

    seven_segment_clk_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_divider (
        .clock      (clock),
        .resetn     (resetn),
        .restart    (state == IDLE),
        .phase_done (phase_done)
    );

    // One-entry pending slot; ready mirrors the slot state one edge later.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            ready         <= 1'b1;
        end else begin
            if (accept) begin
                pending <= D;
            end
            pending_valid <= pending_valid_next;
            ready         <= !pending_valid_next;
        end
    end

    // Shift/latch sequencer; outputs are registered and change only on phase boundaries.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_any) begin
                        state     <= SHIFT_LO;
                        shift_reg <= next_frame;
                        bit_cnt   <= BW'(FW - 1);
                        busy      <= 1'b1;
                        ser_data  <= next_frame[FW-1];
                        ser_clk   <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (phase_done) begin
                        state   <= SHIFT_HI;
                        ser_clk <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_done) begin
                        shift_reg <= shift_reg << 1;
                        ser_clk   <= 1'b0;
                        if (bit_cnt != '0) begin
                            bit_cnt  <= bit_cnt - 1'b1;
                            state    <= SHIFT_LO;
                            ser_data <= shift_reg[FW-2];
                        end else begin
                            state     <= LATCH;
                            ser_latch <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (phase_done) begin
                        ser_latch <= 1'b0;
                        if (start_any) begin
                            state     <= SHIFT_LO;
                            shift_reg <= next_frame;
                            bit_cnt   <= BW'(FW - 1);
                            ser_data  <= next_frame[FW-1];
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            ser_data <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_serial_driver.sv
// tb/tb_seven_segment_serial_driver.sv - self-checking bench for seven_segment_serial_driver
module tb_seven_segment_serial_driver;

    logic clock;
    logic resetn;

    logic [31:0] d_a;
    logic        ld_a;
    logic        ready_a, busy_a, ser_data_a, ser_clk_a, ser_latch_a;

    logic [7:0]  d_b;
    logic        ld_b;
    logic        ready_b, busy_b, ser_data_b, ser_clk_b, ser_latch_b;

    int checks;
    int failures;

    seven_segment_serial_driver #(
        .NUM_DIGITS(4), .CLK_DIV(4), .REFRESH_CYCLES(50000)
    ) dut_a (
        .clock(clock), .resetn(resetn), .D(d_a), .load(ld_a),
        .ready(ready_a), .busy(busy_a), .ser_data(ser_data_a),
        .ser_clk(ser_clk_a), .ser_latch(ser_latch_a)
    );

    seven_segment_serial_driver #(
        .NUM_DIGITS(1), .CLK_DIV(1), .REFRESH_CYCLES(100)
    ) dut_b (
        .clock(clock), .resetn(resetn), .D(d_b), .load(ld_b),
        .ready(ready_b), .busy(busy_b), .ser_data(ser_data_b),
        .ser_clk(ser_clk_b), .ser_latch(ser_latch_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Chain models: shift on ser_clk rise, capture on ser_latch rise.
    logic [31:0] rx_a;
    int          nbits_a;
    logic [31:0] latched_a[$];
    int          busy_cyc_a, latch_cyc_a, busy_falls_a;

    logic [7:0]  rx_b;
    int          nbits_b;
    logic [7:0]  latched_b[$];
    int          busy_cyc_b, toggles_b;
    logic        prev_clk_b;

    initial begin
        rx_a = '0; nbits_a = 0; busy_cyc_a = 0; latch_cyc_a = 0; busy_falls_a = 0;
        rx_b = '0; nbits_b = 0; busy_cyc_b = 0; toggles_b = 0; prev_clk_b = 1'b0;
    end

    always @(posedge ser_clk_a) begin
        rx_a = {rx_a[30:0], ser_data_a};
        nbits_a++;
    end
    always @(posedge ser_latch_a) latched_a.push_back(rx_a);
    always @(negedge busy_a) busy_falls_a++;

    always @(posedge ser_clk_b) begin
        rx_b = {rx_b[6:0], ser_data_b};
        nbits_b++;
    end
    always @(posedge ser_latch_b) latched_b.push_back(rx_b);

    always @(posedge clock) begin
        if (busy_a) busy_cyc_a++;
        if (ser_latch_a) latch_cyc_a++;
        if (busy_b) begin
            busy_cyc_b++;
            if (ser_clk_b != prev_clk_b) toggles_b++;
        end
        prev_clk_b = ser_clk_b;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] d, output int waited);
        waited = 0;
        @(negedge clock);
        while (!ready_a && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        d_a  = d;
        ld_a = 1'b1;
        @(negedge clock);
        ld_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int w;
        w = 0;
        @(negedge clock);
        while (!ready_b && w < 2000) begin
            @(negedge clock);
            w++;
        end
        d_b  = d;
        ld_b = 1'b1;
        @(negedge clock);
        ld_b = 1'b0;
    endtask

    task automatic wait_busy_a(input bit level, input int limit, input string name);
        int k;
        k = 0;
        while (busy_a !== level && k < limit) begin
            @(negedge clock);
            k++;
        end
        check(name, busy_a, level);
    endtask

    task automatic wait_busy_b(input bit level, input int limit, input string name);
        int k;
        k = 0;
        while (busy_b !== level && k < limit) begin
            @(negedge clock);
            k++;
        end
        check(name, busy_b, level);
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] exp_frame;
        int          exp_bits;
        int          exp_busy;
        int          exp_latch;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int waited;
        int n_lat;
        int gap;

        checks = 0; failures = 0;
        resetn = 1'b0; ld_a = 1'b0; d_a = '0; ld_b = 1'b0; d_b = '0;

        vecs[0] = '{32'hA500FF3C, 32'hA500FF3C, 32, 260, 4};
        vecs[1] = '{32'h00000000, 32'h00000000, 32, 260, 4};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32, 260, 4};
        vecs[3] = '{32'h80000001, 32'h80000001, 32, 260, 4};
        vecs[4] = '{32'h3C5AA5C3, 32'h3C5AA5C3, 32, 260, 4};
        vecs[5] = '{32'h01020408, 32'h01020408, 32, 260, 4};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ser_data", ser_data_a, 0);
        check("rst_ser_clk", ser_clk_a, 0);
        check("rst_ser_latch", ser_latch_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", ready_a, 1);
        resetn = 1'b1;
        @(negedge clock);
        check("rel_ready", ready_a, 1);
        check("rel_busy_b", busy_b, 0);

        // No resend before any frame has been sent
        busy_cyc_b = 0;
        repeat (300) @(negedge clock);
        check("b_no_refresh_before_first", busy_cyc_b, 0);

        // Minimal chain, one cycle per half-period
        busy_cyc_b = 0; toggles_b = 0; nbits_b = 0;
        send_b(8'h81);
        wait_busy_b(1'b1, 10, "b_busy_rise");
        wait_busy_b(1'b0, 100, "b_busy_fall");
        check("b_latch_count", latched_b.size(), 1);
        check("b_frame", latched_b[0], 8'h81);
        check("b_busy_cycles", busy_cyc_b, 17);
        check("b_bits", nbits_b, 8);
        check("b_clk_toggles", toggles_b, 16);

`ifdef SEVEN_SEGMENT_AUTO_REFRESH_EN
        gap = 0;
        while (!busy_b && gap < 300) begin
            @(negedge clock);
            gap++;
        end
        check("b_refresh_gap", gap, 100);
        busy_cyc_b = 0;
        wait_busy_b(1'b0, 100, "b_refresh_fall");
        check("b_refresh_count", latched_b.size(), 2);
        check("b_refresh_frame", latched_b[$], 8'h81);
        check("b_refresh_busy", busy_cyc_b, 17);
`else
        gap = 0;
        busy_cyc_b = 0;
        repeat (300) @(negedge clock);
        check("b_stays_idle", busy_cyc_b, gap);
`endif

        // Table-driven single frames
        foreach (vecs[i]) begin
            nbits_a = 0; busy_cyc_a = 0; latch_cyc_a = 0;
            n_lat = latched_a.size();
            send_a(vecs[i].d, waited);
            wait_busy_a(1'b1, 10, "a_busy_rise");
            wait_busy_a(1'b0, 400, "a_busy_fall");
            check("a_latch_count", latched_a.size(), n_lat + 1);
            check("a_frame", latched_a[$], vecs[i].exp_frame);
            check("a_bits", nbits_a, vecs[i].exp_bits);
            check("a_busy_cycles", busy_cyc_a, vecs[i].exp_busy);
            check("a_latch_cycles", latch_cyc_a, vecs[i].exp_latch);
        end

        // Back-to-back frames with a blocked and an ignored load
        busy_cyc_a = 0; busy_falls_a = 0;
        n_lat = latched_a.size();
        send_a(32'h0F0F0F0F, waited);
        repeat (10) @(negedge clock);
        send_a(32'h11223344, waited);
        check("b2b_ready_drop", ready_a, 0);
        d_a  = 32'hDEADBEEF;
        ld_a = 1'b1;
        @(negedge clock);
        ld_a = 1'b0;
        check("b2b_ready_hold", ready_a, 0);
        send_a(32'h55667788, waited);
        check("b2b_waited_for_ready", waited > 200, 1);
        wait_busy_a(1'b0, 1200, "b2b_busy_fall");
        check("b2b_latch_count", latched_a.size(), n_lat + 3);
        check("b2b_frame0", latched_a[n_lat], 32'h0F0F0F0F);
        check("b2b_frame1", latched_a[n_lat+1], 32'h11223344);
        check("b2b_frame2", latched_a[n_lat+2], 32'h55667788);
        check("b2b_busy_cycles", busy_cyc_a, 780);
        check("b2b_busy_falls", busy_falls_a, 1);

        // Reset in the middle of a frame with a frame pending
        n_lat = latched_a.size();
        nbits_a = 0;
        send_a(32'h12345678, waited);
        send_a(32'h9ABCDEF0, waited);
        waited = 0;
        while (nbits_a < 10 && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        check("mid_reached_bit10", nbits_a, 10);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("mid_ser_data", ser_data_a, 0);
        check("mid_ser_clk", ser_clk_a, 0);
        check("mid_ser_latch", ser_latch_a, 0);
        check("mid_busy", busy_a, 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        busy_cyc_a = 0;
        @(negedge clock);
        check("mid_ready_after", ready_a, 1);
        repeat (400) @(negedge clock);
        check("mid_no_latch", latched_a.size(), n_lat);
        check("mid_pending_dropped", busy_cyc_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_serial_driver.md
Name: seven_segment_serial_driver

Overview:
- Downstream stage of the Avalon seven-segment register block.
- Takes a parallel frame of segment patterns (8 bits per digit, NUM_DIGITS digits) and serialises it MSB-first onto a daisy chain of external shift/latch registers (74HC595-style).
- Generates ser_data, ser_clk and ser_latch, and holds a one-entry pending buffer so the bus side can post a new frame while one is shifting.

Parameters:
- NUM_DIGITS, 4, number of 8-bit digit registers in the chain; frame width FW = NUM_DIGITS*8.
- CLK_DIV, 4, clock cycles per ser_clk half-period; legal range 1..255.
- REFRESH_CYCLES, 50000, idle cycles before an automatic resend; used only with the optional feature.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- D  in  FW  frame to send; D[FW-1] is shifted first.
- load  in  1  frame strobe; D is captured when load=1 and ready=1.
- ready  out  1  pending slot free; a load is accepted this cycle.
- busy  out  1  a frame is shifting or latching.
- ser_data  out  1  serial data to the chain.
- ser_clk  out  1  shift clock; the chain samples on the rising edge.
- ser_latch  out  1  storage-register latch pulse, active high.

Behaviour:
- Reset (async assert, sync release):
  - ser_data=0, ser_clk=0, ser_latch=0, busy=0, ready=1.
  - state=IDLE, pending slot empty, shift register 0, divider 0.
  - Reset mid-frame aborts immediately; the partial frame is never latched and the pending frame is discarded.
- Accept:
  - load&ready captures D into the pending slot and sets pending_valid.
  - ready = !pending_valid, registered; it drops the cycle after the accepting edge.
  - load with ready=0 is ignored. No error flag is raised.
- Start: in IDLE with pending_valid, the next edge moves the pending slot into the shift register, clears pending_valid, enters SHIFT_LO and sets busy=1. ready returns to 1 on that same edge.
- State machine: IDLE, SHIFT_LO, SHIFT_HI, LATCH. The divider counts 0..CLK_DIV-1 and each phase lasts exactly CLK_DIV cycles.
  - SHIFT_LO: ser_clk=0 and ser_data=current MSB. Data is set on entry so it is stable a full half-period before the rising edge.
  - SHIFT_HI: ser_clk=1. At phase end, shift left by 1 and decrement the bit counter. Go to SHIFT_LO if bits remain, else go to LATCH.
  - LATCH: ser_clk=0 and ser_latch=1 for CLK_DIV cycles. Then:
    - with pending_valid, return to SHIFT_LO with the next frame (back-to-back, no IDLE cycle);
    - otherwise go to IDLE with busy=0 and ser_data=0.
- Latency: busy lasts (2*FW+1)*CLK_DIV cycles per frame. Defaults give 260 cycles.
- Simultaneous events: a load accepted in the same cycle the pending slot is consumed is legal. The new frame lands in the emptied slot, and the slot update takes priority over the transfer-clear of pending_valid.
- Bit counter wraps to FW-1 at every frame start. It never underflows.

Optional Feature:
- Macro: SEVEN_SEGMENT_AUTO_REFRESH_EN.
- With the macro:
  - A copy of the last fully latched frame is kept.
  - An idle counter runs while state=IDLE and pending_valid=0. When it reaches REFRESH_CYCLES-1, the stored frame is resent exactly as a normal frame, correcting display glitches.
  - The counter clears on any load acceptance and on leaving IDLE.
  - No refresh occurs before the first frame has completed since reset.
- Without the macro: no refresh logic and no REFRESH_CYCLES counter; the block stays in IDLE indefinitely.

Decomposition:
- Shared package seven_segment_pkg holds:
  - state encoding IDLE=2'd0, SHIFT_LO=2'd1, SHIFT_HI=2'd2, LATCH=2'd3;
  - constant SEG_BITS_PER_DIGIT=8.
- One sub-module, seven_segment_clk_divider: phase counter with restart input and one-cycle phase_done output, parameterised by CLK_DIV.

Test Plan:
- Reset, then load D=32'hA5_00_FF_3C (CLK_DIV=4) → 32 ser_clk rising edges sample bits A5,00,FF,3C MSB-first. ser_latch is high for 4 cycles after the last edge, and busy is high for exactly 260 cycles.
- Load frame 32'h11223344 while busy, then load 32'h55667788 → the second load is accepted only once ready=1. Frames stream back-to-back with no IDLE cycle between the latch pulse and the next SHIFT_LO.
- With pending_valid=1, pulse load with 32'hDEADBEEF → the load is ignored, ready stays 0, and the frame sent is the earlier pending one.
- Assert resetn=0 at bit 10 of a frame → all outputs are 0 asynchronously, no ser_latch pulse occurs, ready=1 after release, and the pending frame is dropped.
- CLK_DIV=1, NUM_DIGITS=1, D=8'h81 → ser_clk toggles every cycle and busy lasts 17 cycles. The chain receives 8'h81.
- With SEVEN_SEGMENT_AUTO_REFRESH_EN and REFRESH_CYCLES=100, send 8'h3F and wait → an identical resend starts 100 idle cycles after busy falls. No resend occurs when no frame has been sent since reset.
